// File: rtl/bufuart_pkg.sv
// Shared encodings and constants for the buffered UART.
package bufuart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    localparam int STAT_TX_BUSY    = 0;
    localparam int STAT_RX_NEMPTY  = 1;
    localparam int STAT_RX_FULL    = 2;
    localparam int STAT_FRAME_ERR  = 3;
    localparam int STAT_OVERRUN    = 4;
    localparam int STAT_COUNT_LSB  = 8;
    localparam int STAT_COUNT_W    = 5;

    localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;
    localparam logic [31:0] MIN_PERIOD = 32'd2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO, first-word fall-through: dout shows the head whenever non-empty.
module uart_rx_fifo
    import bufuart_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [RX_DEPTH_LOG2:0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int DEPTH = 1 << RX_DEPTH_LOG2;

    logic [7:0]               mem [DEPTH];
    logic [RX_DEPTH_LOG2-1:0] wr_ptr;
    logic [RX_DEPTH_LOG2-1:0] rd_ptr;
    logic                     do_push;
    logic                     do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (RX_DEPTH_LOG2+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/bufuart.sv
// Buffered UART: divider/data register pair, TX shifter, RX sampler with FIFO and status.
//   state    | meaning
//   RX_IDLE  | line high, waiting for a falling edge
//   RX_START | half a period in, confirm the start bit is still low
//   RX_DATA  | sampling 8 data bits, one per period, LSB first
//   RX_STOP  | sampling the stop bit, then push or flag frame error
module bufuart
    import bufuart_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int DEFAULT_DIV   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        ser_tx,
    input  logic        ser_rx,
    input  logic [3:0]  reg_div_we,
    input  logic [31:0] reg_div_di,
    output logic [31:0] reg_div_do,
    input  logic        reg_dat_we,
    input  logic        reg_dat_re,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    output logic        reg_dat_wait,
    output logic [31:0] reg_stat_do,
    input  logic        reg_stat_clr
);

    logic [31:0] divider;
    logic [31:0] period;
    logic [31:0] half_period;

    logic        tx_busy;
    logic [8:0]  tx_frame;
    logic [3:0]  tx_bits;
    logic [31:0] tx_cnt;

    logic        rx_s1;
    logic        rx_sync;
    rx_state_e   rx_state;
    rx_state_e   rx_next;
    logic [31:0] rx_cnt;
    logic        rx_tc;
    logic [2:0]  rx_bits;
    logic [7:0]  rx_shift;
    logic        rx_load_half;
    logic        rx_load_full;
    logic        rx_push;
    logic        rx_frame_set;

    logic [7:0]               fifo_dout;
    logic [RX_DEPTH_LOG2:0]   rx_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     frame_err;
    logic                     overrun;
    logic                     overrun_set;
    logic                     unused_dat_hi;

    assign unused_dat_hi = ^reg_dat_di[31:8];

    assign period      = (divider < MIN_PERIOD) ? MIN_PERIOD : divider;
    assign half_period = period >> 1;
    assign reg_div_do  = divider;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            divider <= 32'(DEFAULT_DIV);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (reg_div_we[i]) divider[i*8 +: 8] <= reg_div_di[i*8 +: 8];
            end
        end
    end

    // Bit counters reload from period at each boundary, so divider writes land there.
    assign reg_dat_wait = reg_dat_we && tx_busy;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ser_tx   <= 1'b1;
            tx_busy  <= 1'b0;
            tx_frame <= '1;
            tx_bits  <= '0;
            tx_cnt   <= '0;
        end else if (!tx_busy) begin
            if (reg_dat_we) begin
                tx_busy  <= 1'b1;
                ser_tx   <= 1'b0;
                tx_frame <= {1'b1, reg_dat_di[7:0]};
                tx_bits  <= 4'd9;
                tx_cnt   <= period - 32'd1;
            end
        end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 32'd1;
        end else if (tx_bits == '0) begin
            tx_busy <= 1'b0;
        end else begin
            ser_tx   <= tx_frame[0];
            tx_frame <= {1'b1, tx_frame[8:1]};
            tx_bits  <= tx_bits - 4'd1;
            tx_cnt   <= period - 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_s1   <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_s1   <= ser_rx;
            rx_sync <= rx_s1;
        end
    end

    assign rx_tc = (rx_cnt == '0);

    always_ff @(posedge clk) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    always_comb begin
        rx_next      = rx_state;
        rx_load_half = 1'b0;
        rx_load_full = 1'b0;
        rx_push      = 1'b0;
        rx_frame_set = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_next      = RX_START;
                    rx_load_half = 1'b1;
                end
            end
            RX_START: begin
                if (rx_tc) begin
                    if (rx_sync) begin
                        rx_next = RX_IDLE;
                    end else begin
                        rx_next      = RX_DATA;
                        rx_load_full = 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tc) begin
                    rx_load_full = 1'b1;
                    if (rx_bits == 3'd0) rx_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_tc) begin
                    rx_next      = RX_IDLE;
                    rx_push      = rx_sync;
                    rx_frame_set = !rx_sync;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_cnt   <= '0;
            rx_bits  <= '0;
            rx_shift <= '0;
        end else begin
            if (rx_load_half)      rx_cnt <= half_period - 32'd1;
            else if (rx_load_full) rx_cnt <= period - 32'd1;
            else if (!rx_tc)       rx_cnt <= rx_cnt - 32'd1;

            if (rx_state == RX_START && rx_tc) begin
                rx_bits <= 3'd7;
            end else if (rx_state == RX_DATA && rx_tc) begin
                rx_shift <= {rx_sync, rx_shift[7:1]};
                rx_bits  <= rx_bits - 3'd1;
            end
        end
    end

    uart_rx_fifo #(
        .RX_DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rx_push),
        .pop     (reg_dat_re),
        .din     (rx_shift),
        .dout    (fifo_dout),
        .count   (rx_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // A full FIFO is never empty, so any read request here is a real pop.
    assign overrun_set = rx_push && fifo_full && !reg_dat_re;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (rx_frame_set)      frame_err <= 1'b1;
            else if (reg_stat_clr) frame_err <= 1'b0;
            if (overrun_set)       overrun   <= 1'b1;
            else if (reg_stat_clr) overrun   <= 1'b0;
        end
    end

    assign reg_dat_do = fifo_empty ? EMPTY_READ : {24'b0, fifo_dout};

    always_comb begin
        reg_stat_do                                     = '0;
        reg_stat_do[STAT_TX_BUSY]                       = tx_busy;
        reg_stat_do[STAT_RX_NEMPTY]                     = !fifo_empty;
        reg_stat_do[STAT_RX_FULL]                       = fifo_full;
        reg_stat_do[STAT_FRAME_ERR]                     = frame_err;
        reg_stat_do[STAT_OVERRUN]                       = overrun;
        reg_stat_do[STAT_COUNT_LSB +: STAT_COUNT_W]     = STAT_COUNT_W'(rx_count);
    end

endmodule

// File: tb/tb_bufuart.sv
// Directed bench for bufuart: TX framing, wait handshake, RX FIFO, errors, reset.
module tb_bufuart;

    logic        clk;
    logic        reset_n;
    logic        ser_tx;
    logic        ser_rx;
    logic [3:0]  reg_div_we;
    logic [31:0] reg_div_di;
    logic [31:0] reg_div_do;
    logic        reg_dat_we;
    logic        reg_dat_re;
    logic [31:0] reg_dat_di;
    logic [31:0] reg_dat_do;
    logic        reg_dat_wait;
    logic [31:0] reg_stat_do;
    logic        reg_stat_clr;

    int n_vec = 0;
    int n_err = 0;

    bufuart #(
        .RX_DEPTH_LOG2 (4),
        .DEFAULT_DIV   (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ser_tx       (ser_tx),
        .ser_rx       (ser_rx),
        .reg_div_we   (reg_div_we),
        .reg_div_di   (reg_div_di),
        .reg_div_do   (reg_div_do),
        .reg_dat_we   (reg_dat_we),
        .reg_dat_re   (reg_dat_re),
        .reg_dat_di   (reg_dat_di),
        .reg_dat_do   (reg_dat_do),
        .reg_dat_wait (reg_dat_wait),
        .reg_stat_do  (reg_stat_do),
        .reg_stat_clr (reg_stat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] b);
        @(negedge clk);
        reg_dat_we = 1'b1;
        reg_dat_di = {24'hABCDEF, b};
        @(negedge clk);
        reg_dat_we = 1'b0;
    endtask

    // Called at the first sample of the start bit; samples mid-bit at divider 16.
    task automatic sample_tx_frame(output logic [9:0] bits);
        bits = '0;
        for (int b = 0; b < 10; b++) begin
            tick(8);
            bits[b] = ser_tx;
            tick(8);
        end
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop, input int stop_len);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 9; i++) begin
            ser_rx = f[i];
            tick(16);
        end
        ser_rx = f[9];
        tick(stop_len);
        ser_rx = 1'b1;
        tick(4);
    endtask

    task automatic rx_pop();
        reg_dat_re = 1'b1;
        tick(1);
        reg_dat_re = 1'b0;
    endtask

    logic [15:0] got16;
    logic [15:0] exp16;
    logic [7:0]  d55;
    logic [9:0]  frame;
    int          busy_n;
    int          wait_n;

    initial begin
        reset_n      = 1'b0;
        ser_rx       = 1'b1;
        reg_div_we   = '0;
        reg_div_di   = '0;
        reg_dat_we   = 1'b0;
        reg_dat_re   = 1'b0;
        reg_dat_di   = '0;
        reg_stat_clr = 1'b0;
        tick(3);
        chk("rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("rst_div", reg_div_do, 32'd1);
        chk("rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);
        chk("rst_stat", reg_stat_do, 32'h0);
        reset_n = 1'b1;
        tick(2);

        // Divider byte lanes
        reg_div_we = 4'b0001;
        reg_div_di = 32'hAABB_CC10;
        tick(1);
        reg_div_we = 4'b0000;
        chk("div_lane0", reg_div_do, 32'h0000_0010);
        reg_div_we = 4'b0110;
        reg_div_di = 32'h1234_5678;
        tick(1);
        chk("div_lane12", reg_div_do, 32'h0034_5610);
        reg_div_we = 4'b1111;
        reg_div_di = 32'h0000_0010;
        tick(1);
        reg_div_we = 4'b0000;
        chk("div_restore", reg_div_do, 32'h0000_0010);

        // TX 0x55 at 16 clocks per bit
        d55 = 8'h55;
        tx_write(d55);
        busy_n = 0;
        for (int b = 0; b < 10; b++) begin
            got16 = '0;
            for (int i = 0; i < 16; i++) begin
                got16[i] = ser_tx;
                if (reg_stat_do[0]) busy_n++;
                tick(1);
            end
            if (b == 0)      exp16 = 16'h0000;
            else if (b == 9) exp16 = 16'hFFFF;
            else             exp16 = d55[b-1] ? 16'hFFFF : 16'h0000;
            chk($sformatf("tx55_bit%0d", b), 32'(got16), 32'(exp16));
        end
        chk("tx55_busy_clocks", busy_n, 160);
        chk("tx55_busy_end", 32'(reg_stat_do[0]), 32'd0);

        // Back-to-back writes: the second stalls until the first frame ends
        @(negedge clk);
        reg_dat_we = 1'b1;
        reg_dat_di = 32'h0000_0041;
        tick(1);
        reg_dat_di = 32'h0000_0042;
        chk("b2b_wait_on", 32'(reg_dat_wait), 32'd1);
        wait_n = 0;
        while (reg_dat_wait && wait_n < 400) begin
            wait_n++;
            tick(1);
        end
        chk("b2b_wait_clocks", wait_n, 160);
        chk("b2b_idle_gap", 32'(ser_tx), 32'd1);
        tick(1);
        reg_dat_we = 1'b0;
        sample_tx_frame(frame);
        chk("b2b_frame42", 32'(frame), 32'({1'b1, 8'h42, 1'b0}));
        chk("b2b_busy_end", 32'(reg_stat_do[0]), 32'd0);

        // RX two bytes and pops
        rx_send(8'h12, 1'b1, 16);
        rx_send(8'h34, 1'b1, 16);
        chk("rx2_count", 32'(reg_stat_do[12:8]), 32'd2);
        chk("rx2_nonempty", 32'(reg_stat_do[1]), 32'd1);
        chk("rx2_head", reg_dat_do, 32'h12);
        rx_pop();
        chk("rx2_pop1", reg_dat_do, 32'h34);
        rx_pop();
        chk("rx2_pop2", reg_dat_do, 32'hFFFF_FFFF);
        chk("rx2_count0", 32'(reg_stat_do[12:8]), 32'd0);
        rx_pop();
        chk("rx_pop_empty", reg_stat_do, 32'h0);

        // Overrun: 17 bytes, no reads
        for (int i = 0; i < 17; i++) rx_send(8'hA0 + 8'(i), 1'b1, 16);
        chk("ovr_count", 32'(reg_stat_do[12:8]), 32'd16);
        chk("ovr_full", 32'(reg_stat_do[2]), 32'd1);
        chk("ovr_flag", 32'(reg_stat_do[4]), 32'd1);
        chk("ovr_no_ferr", 32'(reg_stat_do[3]), 32'd0);
        reg_stat_clr = 1'b1;
        tick(1);
        reg_stat_clr = 1'b0;
        chk("ovr_clr", 32'(reg_stat_do[4]), 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ovr_order%0d", i), reg_dat_do, 32'hA0 + 32'(i));
            rx_pop();
        end
        chk("ovr_drained", reg_dat_do, 32'hFFFF_FFFF);

        // Frame error, then glitch rejection
        rx_send(8'h77, 1'b1, 16);
        rx_send(8'h5A, 1'b0, 10);
        tick(30);
        chk("ferr_flag", 32'(reg_stat_do[3]), 32'd1);
        chk("ferr_count", 32'(reg_stat_do[12:8]), 32'd1);
        chk("ferr_no_ovr", 32'(reg_stat_do[4]), 32'd0);
        reg_stat_clr = 1'b1;
        tick(1);
        reg_stat_clr = 1'b0;
        chk("ferr_clr", 32'(reg_stat_do[3]), 32'd0);
        ser_rx = 1'b0;
        tick(4);
        ser_rx = 1'b1;
        tick(40);
        chk("glitch_count", 32'(reg_stat_do[12:8]), 32'd1);
        chk("glitch_flags", 32'(reg_stat_do[4:3]), 32'd0);
        chk("glitch_head", reg_dat_do, 32'h77);
        rx_pop();

        // Reset in the middle of a TX frame and an RX frame
        rx_send(8'h66, 1'b1, 16);
        tx_write(8'h99);
        ser_rx = 1'b0;
        tick(40);
        chk("mid_pre_busy", 32'(reg_stat_do[1:0]), 32'd3);
        reset_n = 1'b0;
        ser_rx  = 1'b1;
        tick(1);
        chk("mid_rst_ser_tx", 32'(ser_tx), 32'd1);
        chk("mid_rst_stat", reg_stat_do, 32'h0);
        chk("mid_rst_div", reg_div_do, 32'd1);
        chk("mid_rst_dat_do", reg_dat_do, 32'hFFFF_FFFF);
        reset_n = 1'b1;
        tick(2);

        // Divider 1 clamps to a 2-clock bit period
        tx_write(8'hF0);
        busy_n = 0;
        while (reg_stat_do[0] && busy_n < 100) begin
            busy_n++;
            tick(1);
        end
        chk("minper_busy_clocks", busy_n, 20);
        chk("minper_idle_line", 32'(ser_tx), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bufuart.md
Name: bufuart

Overview:
- Buffered UART peripheral that sits directly behind the CPU memory bus decode, alongside the LED port and RAM.
- Register-compatible with the existing divider/data register pair: the bus-side select and strobe logic drives it unchanged.
- Adds an RX FIFO, a status register and sticky error flags, so the firmware stops losing received bytes while it is busy.

Parameters:
- RX_DEPTH_LOG2, 4, log2 of RX FIFO depth (16 entries).
- DEFAULT_DIV, 1, divider value loaded at reset (clocks per bit).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- ser_tx  out  1  serial transmit line, idle high
- ser_rx  in  1  serial receive line, asynchronous
- reg_div_we  in  4  byte write strobes for divider register
- reg_div_di  in  32  divider write data
- reg_div_do  out  32  divider readback
- reg_dat_we  in  1  TX byte write request
- reg_dat_re  in  1  RX byte read request (pop)
- reg_dat_di  in  32  TX data; bits [7:0] used
- reg_dat_do  out  32  RX data
- reg_dat_wait  out  1  stall for the current data write
- reg_stat_do  out  32  status word
- reg_stat_clr  in  1  clears the sticky error flags

Behaviour:
- Clock is clk. Reset is reset_n: synchronous, active-low.
- Reset values:
  - ser_tx=1, divider=DEFAULT_DIV, FIFO empty, flags=0, TX idle.
  - Outputs follow from this state: reg_dat_wait=0 and reg_dat_do=32'hFFFF_FFFF (FIFO empty).
- Reset mid-frame: a TX frame in progress is aborted and ser_tx goes to 1 on the next edge. A partial RX byte is discarded.
- Divider:
  - Per-byte write, one byte lane per reg_div_we bit. reg_div_do is the full 32-bit value.
  - Effective bit period is max(divider,2) clocks.
  - A new value takes effect at the next bit boundary.
- RX front end:
  - ser_rx passes through a 2-flop synchronizer.
  - Idle state: wait for the synchronized line to go low.
- RX state machine, states IDLE, START, DATA, STOP:
  - START: wait period/2 clocks, then re-sample. If the line is high again it was a glitch: return to IDLE, nothing flagged.
  - DATA: 8 samples, one every period, LSB first.
  - STOP: sample after one more period.
    - Stop bit high: push the byte into the FIFO.
    - Stop bit low: drop the byte and set frame_err.
  - Return to IDLE after STOP in either case.
- FIFO full on push: byte dropped, overrun set, contents unchanged.
- RX read:
  - reg_dat_do is combinational: {24'b0, head} when the FIFO is non-empty, else 32'hFFFF_FFFF.
  - reg_dat_re with FIFO non-empty pops at that edge.
  - reg_dat_re with FIFO empty has no effect.
  - Push and pop in the same cycle: both occur, count unchanged. This holds when full: the pop frees a slot, so no overrun.
- TX:
  - Single holding shift register.
  - reg_dat_wait = reg_dat_we && tx_busy, combinational.
  - reg_dat_we with TX idle: latch di[7:0]; tx_busy=1 from the next cycle.
  - Frame: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts one period.
  - tx_busy clears after the stop bit's full period. A write may be accepted the same cycle tx_busy falls.
- reg_stat_do:
  - [0] tx_busy
  - [1] rx_nonempty
  - [2] rx_full
  - [3] frame_err
  - [4] overrun
  - [12:8] rx_count (0..16)
  - all other bits 0
- reg_stat_clr clears frame_err and overrun. If a new error is raised in the same cycle, the set wins.

Decomposition:
- Shared package holds:
  - RX state encodings (IDLE/START/DATA/STOP).
  - Status bit index constants.
  - Empty-read value 32'hFFFF_FFFF.
  - Minimum period constant 2.
- One sub-module: uart_rx_fifo, a synchronous FIFO with:
  - parameter RX_DEPTH_LOG2
  - ports push, pop, din[7:0], dout[7:0], count, full, empty
  - first-word fall-through behaviour
- TX, RX and register logic live in bufuart.

Test Plan:
- Reset, then write divider 0x00000010 with we=4'b0001. Expected: reg_div_do=0x10. TX byte 0x55 gives a ser_tx low start bit of exactly 16 clocks, then 1,0,1,0,1,0,1,0, then stop high. tx_busy=1 for 160 clocks.
- Write 0x41, then immediately 0x42. Expected: reg_dat_wait=1 until the 0x41 frame ends, then 0x42 is accepted. Two back-to-back frames with no idle gap beyond one cycle.
- Drive RX frames 0x12, 0x34 at divider 16. Expected: rx_count=2, reg_dat_do=0x12. After one read pop, reg_dat_do=0x34. After a second pop, reg_dat_do=0xFFFFFFFF and rx_count=0.
- Drive 17 RX bytes with no reads. Expected: rx_count=16, rx_full=1, overrun=1, FIFO holds the first 16 bytes in order. reg_stat_clr then clears overrun.
- Drive an RX frame with stop bit 0. Expected: frame_err=1, rx_count unchanged. Separately, a low pulse of 4 clocks at divider 16 is rejected as a glitch: no push, no flag.
- Assert reset_n=0 for 1 cycle mid-TX and mid-RX. Expected: ser_tx=1 next cycle, tx_busy=0, FIFO empty, divider=DEFAULT_DIV.
